// File: rtl/cond_resolve_unit.sv
// -----------------------------------------------------------------------------
// cond_resolve_unit
// Consumer end of the ALU flag interface. Latches ALU N/Z/C/V into the
// architectural flags register, counts flag-setting ops that have issued but
// not yet written back, and resolves B.cond requests once flags are current.
//
// Optional feature macro: FLAG_FWD_EN
//   defined   - when the last outstanding op writes its flags in the same cycle
//               a request would otherwise wait, the incoming ALU flags are
//               evaluated directly (one cycle saved).
//   undefined - evaluation always uses the registered flags_q.
// -----------------------------------------------------------------------------
module cond_resolve_unit #(
    parameter  int PEND_DEPTH = 4,
    localparam int CNT_W      = $clog2(PEND_DEPTH + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flag_issue,
    output logic       issue_ready,
    input  logic       flag_wr_en,
    input  logic       negative,
    input  logic       zero,
    input  logic       overflow,
    input  logic       carry_out,
    output logic [3:0] flags_q,
    input  logic       br_valid,
    input  logic [3:0] br_cond,
    output logic       br_ready,
    output logic       res_valid,
    output logic       res_taken,
    input  logic       res_ready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PEND_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] pend_cnt;
    logic [3:0]       cond_q;
    logic [3:0]       cond_d;
    logic             taken_d;
    logic [3:0]       alu_flags;
    logic             issue_acc;
    logic             wr_dec;
    logic             br_acc;
    logic             fwd_hit;

    // Flags in {N,Z,C,V} order, the same layout as flags_q.
    assign alu_flags = {negative, zero, carry_out, overflow};

    assign issue_ready = !reset && (pend_cnt < CNT_MAX);
    assign br_ready    = !reset && (state == ST_IDLE);
    assign res_valid   = (state == ST_RESP);

    assign issue_acc = flag_issue && issue_ready;
    // A write with nothing outstanding still updates flags but must not underflow.
    assign wr_dec    = flag_wr_en && (pend_cnt != CNT_ZERO);
    assign br_acc    = br_valid && br_ready;

`ifdef FLAG_FWD_EN
    // Last outstanding op writes back now and nothing new issues this cycle.
    assign fwd_hit = (pend_cnt == CNT_ONE) && flag_wr_en && !issue_acc;
`else
    assign fwd_hit = 1'b0;
`endif

    // ARM condition code evaluation against {N,Z,C,V}.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return c;
            4'h3:    return !c;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return c && !z;
            4'h9:    return !c || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // Next-state, latched condition and resolution value for the request FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d = state;
        cond_d  = cond_q;
        taken_d = res_taken;
        case (state)
            ST_IDLE: begin
                if (br_acc) begin
                    cond_d = br_cond;
                    // pend_cnt is the pre-issue count, so an op issued this
                    // same cycle is not waited for.
                    if (pend_cnt == CNT_ZERO) begin
                        taken_d = cond_eval(br_cond, flags_q);
                        state_d = ST_RESP;
                    end else if (fwd_hit) begin
                        taken_d = cond_eval(br_cond, alu_flags);
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (pend_cnt == CNT_ZERO) begin
                    taken_d = cond_eval(cond_q, flags_q);
                    state_d = ST_RESP;
                end else if (fwd_hit) begin
                    taken_d = cond_eval(cond_q, alu_flags);
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered state: FSM, condition, result, flags and pending counter.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, independent of statement order.
        if (reset) begin
            state     <= ST_IDLE;
            cond_q    <= 4'h0;
            res_taken <= 1'b0;
            flags_q   <= 4'b0000;
            pend_cnt  <= CNT_ZERO;
        end else begin
            state     <= state_d;
            cond_q    <= cond_d;
            res_taken <= taken_d;
            if (flag_wr_en) flags_q <= alu_flags;
            if (issue_acc && !wr_dec)      pend_cnt <= pend_cnt + CNT_ONE;
            else if (wr_dec && !issue_acc) pend_cnt <= pend_cnt - CNT_ONE;
        end
    end

endmodule

// File: tb/tb_cond_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_cond_resolve_unit
// Directed self-checking bench for cond_resolve_unit. Expectations that depend
// on the FLAG_FWD_EN build option are selected with the same macro.
// -----------------------------------------------------------------------------
module tb_cond_resolve_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       flag_issue;
    logic       issue_ready;
    logic       flag_wr_en;
    logic       negative, zero, overflow, carry_out;
    logic [3:0] flags_q;
    logic       br_valid;
    logic [3:0] br_cond;
    logic       br_ready;
    logic       res_valid;
    logic       res_taken;
    logic       res_ready;

    int checks = 0;
    int errors = 0;

    cond_resolve_unit dut (
        .clk        (clk),
        .reset      (reset),
        .flag_issue (flag_issue),
        .issue_ready(issue_ready),
        .flag_wr_en (flag_wr_en),
        .negative   (negative),
        .zero       (zero),
        .overflow   (overflow),
        .carry_out  (carry_out),
        .flags_q    (flags_q),
        .br_valid   (br_valid),
        .br_cond    (br_cond),
        .br_ready   (br_ready),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .res_ready  (res_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_alu(input logic n, input logic z, input logic c, input logic v);
        negative  = n;
        zero      = z;
        carry_out = c;
        overflow  = v;
    endtask

    // Issue a request with nothing outstanding; result must appear next cycle.
    task automatic req(input string tag, input logic [3:0] c, input logic exp_taken);
        br_valid = 1'b1;
        br_cond  = c;
        tick();
        br_valid = 1'b0;
        check({tag, "_valid"}, {3'b0, res_valid}, 4'd1);
        check({tag, "_taken"}, {3'b0, res_taken}, {3'b0, exp_taken});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_done"}, {3'b0, res_valid}, 4'd0);
    endtask

    initial begin
        reset      = 1'b1;
        flag_issue = 1'b0;
        flag_wr_en = 1'b0;
        set_alu(1'b0, 1'b0, 1'b0, 1'b0);
        br_valid   = 1'b0;
        br_cond    = 4'h0;
        res_ready  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_flags", flags_q, 4'b0000);
        check("rst_res_valid", {3'b0, res_valid}, 4'd0);
        check("rst_res_taken", {3'b0, res_taken}, 4'd0);
        check("rst_br_ready", {3'b0, br_ready}, 4'd0);
        check("rst_issue_ready", {3'b0, issue_ready}, 4'd0);
        reset = 1'b0;
        settle();
        check("idle_br_ready", {3'b0, br_ready}, 4'd1);
        check("idle_issue_ready", {3'b0, issue_ready}, 4'd1);

        // Always-true condition with no ops outstanding
        req("al_e", 4'hE, 1'b1);
        check("al_flags", flags_q, 4'b0000);

        // Flags N=1 -> {N,Z,C,V}=1000
        flag_wr_en = 1'b1;
        set_alu(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        flag_wr_en = 1'b0;
        check("wr_n_flags", flags_q, 4'b1000);
        req("lt", 4'hB, 1'b1);
        req("ge", 4'hA, 1'b0);
        req("mi", 4'h4, 1'b1);
        req("eq", 4'h0, 1'b0);

        // Flags Z=1,C=1 -> 0110
        flag_wr_en = 1'b1;
        set_alu(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        flag_wr_en = 1'b0;
        check("wr_zc_flags", flags_q, 4'b0110);
        req("hi", 4'h8, 1'b0);
        req("ls", 4'h9, 1'b1);
        req("gt", 4'hC, 1'b0);
        req("le", 4'hD, 1'b1);
        req("ne", 4'h1, 1'b0);
        req("hs", 4'h2, 1'b1);
        req("lo", 4'h3, 1'b0);
        req("vs", 4'h6, 1'b0);
        req("vc", 4'h7, 1'b1);
        req("pl", 4'h5, 1'b1);
        req("al_f", 4'hF, 1'b1);

        // Two outstanding ops, EQ waits for the second write (Z=1)
        flag_issue = 1'b1;
        tick();
        tick();
        flag_issue = 1'b0;
        br_valid   = 1'b1;
        br_cond    = 4'h0;
        tick();
        br_valid = 1'b0;
        check("wait_res_valid", {3'b0, res_valid}, 4'd0);
        check("wait_br_ready", {3'b0, br_ready}, 4'd0);
        flag_wr_en = 1'b1;
        set_alu(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        flag_wr_en = 1'b0;
        check("wait_wr1", {3'b0, res_valid}, 4'd0);
        tick();
        check("wait_gap", {3'b0, res_valid}, 4'd0);
        flag_wr_en = 1'b1;
        set_alu(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        flag_wr_en = 1'b0;
`ifdef FLAG_FWD_EN
        check("wait_wr2_fwd", {3'b0, res_valid}, 4'd1);
`else
        check("wait_wr2", {3'b0, res_valid}, 4'd0);
        tick();
        check("wait_resolve", {3'b0, res_valid}, 4'd1);
`endif
        check("wait_taken", {3'b0, res_taken}, 4'd1);
        check("wait_flags", flags_q, 4'b0100);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Fill the pending counter, overflow attempt, simultaneous issue+write
        flag_issue = 1'b1;
        repeat (4) tick();
        check("full_issue_ready", {3'b0, issue_ready}, 4'd0);
        tick();
        check("full_ignored", {3'b0, issue_ready}, 4'd0);
        flag_issue = 1'b0;
        flag_wr_en = 1'b1;
        set_alu(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        flag_issue = 1'b1;
        tick();
        flag_issue = 1'b0;
        flag_wr_en = 1'b0;
        settle();
        check("cnt3_hold", {3'b0, issue_ready}, 4'd1);
        flag_issue = 1'b1;
        tick();
        flag_issue = 1'b0;
        settle();
        check("cnt4_again", {3'b0, issue_ready}, 4'd0);
        flag_wr_en = 1'b1;
        repeat (4) tick();
        check("drained_ready", {3'b0, issue_ready}, 4'd1);
        set_alu(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        flag_wr_en = 1'b0;
        check("wr_at_zero_flags", flags_q, 4'b1000);
        req("no_underflow_mi", 4'h4, 1'b1);

        // Result held while consumer stalls; no accept in the release cycle
        br_valid = 1'b1;
        br_cond  = 4'h1;
        tick();
        check("hold_valid0", {3'b0, res_valid}, 4'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", {3'b0, res_valid}, 4'd1);
            check("hold_taken", {3'b0, res_taken}, 4'd1);
            check("hold_br_ready", {3'b0, br_ready}, 4'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("release_valid", {3'b0, res_valid}, 4'd0);
        check("release_br_ready", {3'b0, br_ready}, 4'd1);
        tick();
        br_valid = 1'b0;
        check("reaccept_valid", {3'b0, res_valid}, 4'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Reset while waiting drops the request and clears all state
        flag_issue = 1'b1;
        tick();
        flag_issue = 1'b0;
        br_valid   = 1'b1;
        br_cond    = 4'h0;
        tick();
        br_valid = 1'b0;
        check("pre_rst_wait", {3'b0, br_ready}, 4'd0);
        reset = 1'b1;
        settle();
        check("in_rst_br_ready", {3'b0, br_ready}, 4'd0);
        check("in_rst_issue_ready", {3'b0, issue_ready}, 4'd0);
        tick();
        check("mid_rst_flags", flags_q, 4'b0000);
        check("mid_rst_valid", {3'b0, res_valid}, 4'd0);
        reset = 1'b0;
        settle();
        check("post_rst_br_ready", {3'b0, br_ready}, 4'd1);
        req("post_rst_al", 4'hF, 1'b1);

        // One op outstanding; GT requested as it writes Z=0,N=V=1 (flags_q has Z=1)
        flag_wr_en = 1'b1;
        set_alu(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        flag_wr_en = 1'b0;
        flag_issue = 1'b1;
        tick();
        flag_issue = 1'b0;
        br_valid   = 1'b1;
        br_cond    = 4'hC;
        flag_wr_en = 1'b1;
        set_alu(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        br_valid   = 1'b0;
        flag_wr_en = 1'b0;
`ifdef FLAG_FWD_EN
        check("fwd_valid", {3'b0, res_valid}, 4'd1);
`else
        check("fwd_off_wait", {3'b0, res_valid}, 4'd0);
        tick();
        check("fwd_off_valid", {3'b0, res_valid}, 4'd1);
`endif
        check("fwd_taken", {3'b0, res_taken}, 4'd1);
        check("fwd_flags", flags_q, 4'b1001);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
